// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: reset vector, PC step, state encoding
// and the word-alignment mask used for redirect targets.
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam int unsigned PC_STEP_DEF      = 4;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        REQ,
        DRAIN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake: req/addr out, ack/rdata back.
// master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_out_buf.sv
// One-entry output buffer towards decode (instr, instr_pc, pc_plus4, valid).
// Ports: clk, reset, load/flush/consume controls, load data, buffered outputs.
module fetch_out_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic        consume,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_plus4,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus4    <= '0;
        end else if (load) begin
            instr_valid <= 1'b1;
            instr       <= d_instr;
            instr_pc    <= d_pc;
            pc_plus4    <= d_pc_plus4;
        end else if (flush || consume) begin
            // Only the valid bit drops; stale data is harmless.
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch FSM (REQ/DRAIN/HOLD) feeding the decode buffer.
// Ports: clk, reset, redirect_valid/target, stall, imem (master),
// instr_valid/instr/instr_pc/pc_plus4 to decode, misalign_err.
// Macro PC_ALIGN_CHECK_EN: aligns redirect targets, flags sticky misalign_err.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int unsigned PC_STEP      = PC_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_target,
    input  logic                    stall,
    pc_fetch_unit_if.master         imem,
    output logic                    instr_valid,
    output logic [31:0]             instr,
    output logic [31:0]             instr_pc,
    output logic [31:0]             pc_plus4,
    output logic                    misalign_err
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  target;
    logic         load, flush, consume, buf_free;

`ifdef PC_ALIGN_CHECK_EN
    assign target = redirect_target & WORD_ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign target       = redirect_target;
    assign misalign_err = 1'b0;
`endif

    // Decode takes the buffer whenever it is valid and not stalled.
    assign consume  = instr_valid && !stall;
    assign buf_free = !instr_valid || !stall;

    assign imem.imem_req  = !reset && (state_q != HOLD);
    assign imem.imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_VECTOR;
            drain_addr_q <= RESET_VECTOR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        load         = 1'b0;
        flush        = 1'b0;
        unique case (state_q)
            REQ: begin
                if (redirect_valid) begin
                    pc_d  = target;
                    flush = 1'b1;
                    // An outstanding request must still complete.
                    if (!imem.imem_ack) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem.imem_ack) begin
                    // A stalled entry is never overwritten: the word is
                    // dropped and refetched from the unchanged pc.
                    load = buf_free;
                    if (buf_free) begin
                        pc_d = pc_q + STEP;
                    end
                    state_d = stall ? HOLD : REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d = target;
                end
                if (imem.imem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    flush   = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    fetch_out_buf u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .flush       (flush),
        .consume     (consume),
        .d_instr     (imem.imem_rdata),
        .d_pc        (pc_q),
        .d_pc_plus4  (pc_q + STEP),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch scenarios plus
// randomized stall/redirect/ack traffic against a stream-level model.
module tb_pc_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;

    pc_fetch_unit_if mif ();

    pc_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem            (mif),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .pc_plus4        (pc_plus4),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    logic [31:0] ack_q[$];
    logic [31:0] redir_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        return {t[31:2], 2'b00};
`else
        return t;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; the memory acks only an active request.
    task automatic step(input bit st, input bit rd,
                        input logic [31:0] tgt, input bit ack_en);
        @(posedge clk);
        #1;
        stall           = st;
        redirect_valid  = rd;
        redirect_target = tgt;
        if (rd) redir_q.push_back(tgt);
        mif.imem_ack   = ack_en && mif.imem_req;
        mif.imem_rdata = mem_word(mif.imem_addr);
        if (mif.imem_ack) ack_q.push_back(mif.imem_addr);
    endtask

    // Monitor / reference model state
    logic [31:0] exp_pc;
    logic        discard;
    logic        p_live, p_valid, p_stall, p_redir, p_req, p_ack;
    logic [31:0] p_addr, p_data, p_bus_addr;
    logic [31:0] p_instr, p_ipc, p_pp4;
    logic        live;
    logic [31:0] a;

    always @(negedge clk) begin
        if (!mon_en) begin
            exp_pc  = RESET_VECTOR_DEF;
            discard = 1'b0;
            {p_live, p_valid, p_stall, p_redir, p_req, p_ack} = '0;
            p_addr = '0; p_data = '0; p_bus_addr = '0;
            p_instr = '0; p_ipc = '0; p_pp4 = '0;
            ack_q.delete();
            redir_q.delete();
        end else begin
            if (p_live) begin
                chk("buf_valid_load", 32'(instr_valid), 32'd1);
                chk("buf_instr", instr, p_data);
                chk("buf_pc", instr_pc, p_addr);
                chk("buf_pc_plus4", pc_plus4, p_addr + 32'd4);
            end else if (p_valid && p_stall && !p_redir) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_instr", instr, p_instr);
                chk("hold_pc", instr_pc, p_ipc);
                chk("hold_pc_plus4", pc_plus4, p_pp4);
            end else begin
                chk("buf_empty", 32'(instr_valid), 32'd0);
            end
            if (p_req && !p_ack) begin
                chk("req_held", 32'(mif.imem_req), 32'd1);
                chk("addr_stable", mif.imem_addr, p_bus_addr);
            end
            live = 1'b0;
            if (mif.imem_ack) begin
                if (ack_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ack_q: ack with no issued response");
                end else begin
                    a = ack_q.pop_front();
                    live = !discard && !redirect_valid &&
                           (!instr_valid || !stall);
                    if (live) begin
                        chk("stream_pc", a, exp_pc);
                        exp_pc = exp_pc + 32'd4;
                    end
                end
            end
            if (mif.imem_req && mif.imem_ack) discard = 1'b0;
            else if (redirect_valid && mif.imem_req) discard = 1'b1;
            if (redirect_valid) begin
                if (redir_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL redir_q: redirect not recorded");
                end else begin
                    exp_pc = eff_target(redir_q.pop_front());
                end
            end
            p_live     = live;
            p_addr     = a;
            p_data     = mem_word(a);
            p_valid    = instr_valid;
            p_stall    = stall;
            p_redir    = redirect_valid;
            p_req      = mif.imem_req;
            p_ack      = mif.imem_ack;
            p_bus_addr = mif.imem_addr;
            p_instr    = instr;
            p_ipc      = instr_pc;
            p_pp4      = pc_plus4;
        end
    end

    logic [31:0] r, tgt;
    logic [31:0] exp_mis_addr;
    logic [31:0] exp_mis_err;

    initial begin
        mif.imem_ack   = 1'b0;
        mif.imem_rdata = '0;
        a = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mif.imem_req), 32'd0);
        chk("rst_addr", mif.imem_addr, RESET_VECTOR_DEF);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);

        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(mif.imem_req), 32'd1);
        chk("first_addr", mif.imem_addr, 32'd0);

        // Sequential fetch, then stall with a refused ack
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            chk("seq_addr", mif.imem_addr, 32'(i * 4));
        end
        step(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("seq_addr12", mif.imem_addr, 32'd12);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            chk("hold_no_req", 32'(mif.imem_req), 32'd0);
        end
        step(1'b0, 1'b0, '0, 1'b0);

        // Redirect with a pending request: drain old address
        step(1'b0, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        chk("redir_req_addr", mif.imem_addr, 32'd12);
        step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("drain_addr", mif.imem_addr, 32'd12);
        chk("drain_req", 32'(mif.imem_req), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Redirect coinciding with ack
        step(1'b0, 1'b1, 32'h200, 1'b1);
        @(negedge clk);
        chk("after_drain_addr", mif.imem_addr, 32'h100);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk);
        chk("redir_ack_addr", mif.imem_addr, 32'h200);
        chk("redir_ack_valid", 32'(instr_valid), 32'd0);

        // Wrap at the top of the address space
        step(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("wrap_req_addr", mif.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'd0);
        chk("wrap_next_addr", mif.imem_addr, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 + {28'd0, r[1:0], 2'b00};
            else
                tgt = r & 32'hFFFF_FFFC;
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 tgt, $urandom_range(0, 9) < 6);
        end

        // Misaligned redirect target
`ifdef PC_ALIGN_CHECK_EN
        exp_mis_addr = 32'h100;
        exp_mis_err  = 32'd1;
`else
        exp_mis_addr = 32'h102;
        exp_mis_err  = 32'd0;
`endif
        step(1'b0, 1'b1, 32'h102, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("misalign_addr", mif.imem_addr, exp_mis_addr);
        chk("misalign_err", 32'(misalign_err), exp_mis_err);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("misalign_sticky", 32'(misalign_err), exp_mis_err);

        @(posedge clk);
        #1;
        mon_en          = 1'b0;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        stall           = 1'b0;
        mif.imem_ack    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rerst_misalign", 32'(misalign_err), 32'd0);
        chk("rerst_req", 32'(mif.imem_req), 32'd0);
        chk("rerst_addr", mif.imem_addr, RESET_VECTOR_DEF);
        chk("rerst_valid", 32'(instr_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
